scp: RTL and testbench

Single-cycle RV32I processor core executing one instruction per clock from an external instruction memory and accessing an external data memory. It holds the PC, a 32×32 register file, immediate extension, ALU and control decode; instruction and data memories are outside the block. It is the CPU datapath/controller top of the processor subsystem.

---
 rtl/scp.sv | 147 ++++++++++++++
 tb/tb_scp.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/scp.sv
// Single-cycle RV32I core (lw/sw/R-ALU/I-ALU/beq/jal): PC, register file, decode,
// immediate extension and ALU; instruction and data memories live outside.
module scp (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] PC,
  input  logic [31:0] Instr,
  output logic        MemWrite,
  output logic [31:0] ALUResult,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData
);

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_RTYPE  = 7'b0110011,
    OP_IALU   = 7'b0010011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_op_e;
  typedef enum logic [1:0] {RES_ALU, RES_MEM, RES_PC4} res_src_e;

  logic [31:0] pc_q, pc_d;
  logic [31:0] rf_q [32];

  opcode_e     opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_j;
  logic [31:0] src_a, src_b, rs2_val, alu_imm;
  logic [31:0] pc_plus4, pc_target, alu_y;
  logic        reg_write, mem_write, src_b_imm, branch, jump, zero;
  alu_op_e     alu_op;
  res_src_e    res_src;
  logic        rf_we_d;
  logic [31:0] rf_wdata_d;

  assign opcode = opcode_e'(Instr[6:0]);
  assign funct3 = Instr[14:12];
  assign funct7 = Instr[31:25];
  assign rs1    = Instr[19:15];
  assign rs2    = Instr[24:20];
  assign rd     = Instr[11:7];

  assign imm_i = {{20{Instr[31]}}, Instr[31:20]};
  assign imm_s = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
  assign imm_b = {{20{Instr[31]}}, Instr[7], Instr[30:25], Instr[11:8], 1'b0};
  assign imm_j = {{12{Instr[31]}}, Instr[19:12], Instr[20], Instr[30:21], 1'b0};

  always_comb begin
    reg_write = 1'b0;
    mem_write = 1'b0;
    src_b_imm = 1'b1;
    alu_imm   = imm_i;
    alu_op    = ALU_ADD;
    branch    = 1'b0;
    jump      = 1'b0;
    res_src   = RES_ALU;
    case (opcode)
      OP_LOAD: if (funct3 == 3'b010) begin
        reg_write = 1'b1;
        res_src   = RES_MEM;
      end
      OP_STORE: if (funct3 == 3'b010) begin
        mem_write = 1'b1;
        alu_imm   = imm_s;
      end
      OP_RTYPE, OP_IALU: begin
        src_b_imm = (opcode == OP_IALU);
        reg_write = 1'b1;
        case (funct3)
          3'b000:  alu_op = (opcode == OP_RTYPE && funct7[5]) ? ALU_SUB : ALU_ADD;
          3'b111:  alu_op = ALU_AND;
          3'b110:  alu_op = ALU_OR;
          3'b010:  alu_op = ALU_SLT;
          default: reg_write = 1'b0;
        endcase
        // R-type only accepts funct7=0, or 0100000 for sub
        if (opcode == OP_RTYPE &&
            !(funct7 == 7'b0000000 || (funct7 == 7'b0100000 && funct3 == 3'b000)))
          reg_write = 1'b0;
      end
      OP_BRANCH: if (funct3 == 3'b000) begin
        src_b_imm = 1'b0;
        alu_op    = ALU_SUB;
        branch    = 1'b1;
      end
      OP_JAL: begin
        reg_write = 1'b1;
        jump      = 1'b1;
        res_src   = RES_PC4;
      end
      default: ;
    endcase
  end

  assign src_a   = (rs1 == 5'd0) ? '0 : rf_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : rf_q[rs2];
  assign src_b   = src_b_imm ? alu_imm : rs2_val;

  always_comb begin
    alu_y = src_a + src_b;
    case (alu_op)
      ALU_SUB: alu_y = src_a - src_b;
      ALU_AND: alu_y = src_a & src_b;
      ALU_OR:  alu_y = src_a | src_b;
      ALU_SLT: alu_y = {31'b0, $signed(src_a) < $signed(src_b)};
      default: alu_y = src_a + src_b;
    endcase
  end

  assign zero      = (alu_y == '0);
  assign pc_plus4  = pc_q + 32'd4;
  assign pc_target = pc_q + (jump ? imm_j : imm_b);

  always_comb begin
    pc_d = pc_plus4;
    if (jump || (branch && zero)) pc_d = pc_target;
    if (reset) pc_d = '0;
  end

  always_comb begin
    rf_we_d    = reg_write && (rd != 5'd0) && !reset;
    rf_wdata_d = alu_y;
    case (res_src)
      RES_MEM: rf_wdata_d = ReadData;
      RES_PC4: rf_wdata_d = pc_plus4;
      default: rf_wdata_d = alu_y;
    endcase
  end

  always_ff @(posedge clk) begin
    pc_q <= pc_d;
    if (reset) rf_q <= '{default: '0};
    else if (rf_we_d) rf_q[rd] <= rf_wdata_d;
  end

  assign PC        = pc_q;
  assign ALUResult = alu_y;
  assign WriteData = rs2_val;
  assign MemWrite  = mem_write && !reset;

endmodule

// File: tb/tb_scp.sv
// Directed bench for scp: an instruction-level reference model checked every cycle,
// plus hand-computed literal expectations along the program.
module tb_scp;
  logic        clk, reset;
  logic [31:0] PC, Instr, ALUResult, WriteData, ReadData;
  logic        MemWrite;

  int errors = 0;
  int checks = 0;
  bit chk_on = 0;

  logic [31:0] m_pc;
  logic [31:0] m_regs [32];

  scp dut (
    .clk(clk), .reset(reset), .PC(PC), .Instr(Instr), .MemWrite(MemWrite),
    .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(ReadData)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Architectural semantics of one instruction against the model state.
  function automatic void model_eval(input logic [31:0] ins, input logic [31:0] rdata,
      output logic [31:0] alu, output bit alu_ok, output bit mw,
      output logic [31:0] npc, output bit wr, output logic [31:0] wd);
    logic [31:0] a, b, ii, is, ib, ij;
    logic [2:0] f3;
    logic [6:0] f7;
    a  = m_regs[ins[19:15]];
    b  = m_regs[ins[24:20]];
    f3 = ins[14:12];
    f7 = ins[31:25];
    ii = {{20{ins[31]}}, ins[31:20]};
    is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    ib = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    ij = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    alu = 0; alu_ok = 0; mw = 0; npc = m_pc + 4; wr = 0; wd = 0;
    case (ins[6:0])
      7'b0000011: if (f3 == 2) begin alu = a + ii; alu_ok = 1; wr = 1; wd = rdata; end
      7'b0100011: if (f3 == 2) begin alu = a + is; alu_ok = 1; mw = 1; end
      7'b0110011: begin
        alu_ok = 1; wr = 1;
        if (f7 == 7'h20 && f3 == 0) alu = a - b;
        else if (f7 == 0 && f3 == 0) alu = a + b;
        else if (f7 == 0 && f3 == 7) alu = a & b;
        else if (f7 == 0 && f3 == 6) alu = a | b;
        else if (f7 == 0 && f3 == 2) alu = ($signed(a) < $signed(b)) ? 1 : 0;
        else begin alu_ok = 0; wr = 0; end
        wd = alu;
      end
      7'b0010011: begin
        alu_ok = 1; wr = 1;
        if (f3 == 0) alu = a + ii;
        else if (f3 == 7) alu = a & ii;
        else if (f3 == 6) alu = a | ii;
        else if (f3 == 2) alu = ($signed(a) < $signed(ii)) ? 1 : 0;
        else begin alu_ok = 0; wr = 0; end
        wd = alu;
      end
      7'b1100011: if (f3 == 0) begin
        alu = a - b; alu_ok = 1;
        if (a == b) npc = m_pc + ib;
      end
      7'b1101111: begin wr = 1; wd = m_pc + 4; npc = m_pc + ij; end
      default: ;
    endcase
  endfunction

  task automatic commit();
    logic [31:0] alu, npc, wd;
    bit ok, mw, wr;
    if (reset) begin
      m_pc = 0;
      for (int i = 0; i < 32; i++) m_regs[i] = 0;
    end else begin
      model_eval(Instr, ReadData, alu, ok, mw, npc, wr, wd);
      if (wr && Instr[11:7] != 0) m_regs[Instr[11:7]] = wd;
      m_pc = npc;
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] alu, npc, wd;
    bit ok, mw, wr;
    if (chk_on) begin
      chk("pc", PC, m_pc);
      if (reset) chk("memwrite_rst", {31'b0, MemWrite}, 0);
      else begin
        model_eval(Instr, ReadData, alu, ok, mw, npc, wr, wd);
        chk("memwrite", {31'b0, MemWrite}, {31'b0, mw});
        chk("writedata", WriteData, m_regs[Instr[24:20]]);
        if (ok) chk("aluresult", ALUResult, alu);
      end
    end
  end

  task automatic run(input logic [31:0] ins, input logic [31:0] rdata,
                     input bit lit_en, input logic [31:0] exp_alu);
    Instr = ins; ReadData = rdata;
    #2;
    if (lit_en) chk("alu_lit", ALUResult, exp_alu);
    @(posedge clk); commit(); #1;
  endtask

  initial begin
    reset = 1; Instr = 32'h0471AA23; ReadData = 0;
    @(posedge clk); commit(); #1;
    chk_on = 1;
    @(posedge clk); commit(); #1;
    chk("pc_reset", PC, 0);
    chk("memwrite_in_reset", {31'b0, MemWrite}, 0);
    reset = 0;

    run(32'h00500113, 0, 1, 5);
    chk("pc_after1", PC, 4);
    run(32'h00C00193, 0, 1, 12);
    chk("pc_after2", PC, 8);
    run(32'hFF718393, 0, 1, 3);
    run(32'h0023E233, 0, 1, 7);
    run(32'h0041F2B3, 0, 1, 4);
    chk("pc_after5", PC, 20);

    run(32'h40310333, 0, 1, 32'hFFFFFFF9);
    run(32'h0031A433, 0, 1, 0);
    run(32'h0021A433, 0, 1, 0);
    run(32'h00312433, 0, 1, 1);

    Instr = 32'h0471AA23; ReadData = 0;
    #2;
    chk("sw_memwrite", {31'b0, MemWrite}, 1);
    chk("sw_addr", ALUResult, 96);
    chk("sw_data", WriteData, 3);
    @(posedge clk); commit(); #1;

    run(32'h0601A103, 3, 1, 108);
    run(32'h000104B3, 0, 1, 3);
    chk("pc_before_beq", PC, 48);
    run(32'h00000463, 0, 0, 0);
    chk("beq_taken_pc", PC, 56);
    run(32'h00310463, 0, 0, 0);
    chk("beq_not_taken_pc", PC, 60);
    run(32'h010000EF, 0, 0, 0);
    chk("jal_pc", PC, 76);
    run(32'h00008533, 0, 1, 64);
    run(32'h00700013, 0, 1, 7);
    run(32'h000000B3, 0, 1, 0);
    run(32'hFFFFFFFF, 0, 0, 0);
    chk("illegal_pc", PC, 92);

    reset = 1;
    run(32'h06300593, 0, 0, 0);
    chk("pc_midreset", PC, 0);
    reset = 0;
    run(32'h00058633, 0, 1, 0);
    run(32'h000286B3, 0, 1, 0);
    chk("pc_after_midreset", PC, 8);

    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
